mem_wb_stage: RTL
=================

Name: mem_wb_stage

Overview:
- MEM/WB pipeline register and write-back formatter of the 5-stage MIPS32 core.
- Captures memory-stage results and extracts and sign/zero-extends load data.
- Drives the register file write port (we/waddr/wdata), plus HI/LO write-back when built in.
- Handles pipeline stall bubbles and flushes, and keeps a retired-instruction counter for debug.

Parameters:
- DATA_W, 32, datapath width (fixed 32 for MIPS32; kept for package consistency)
- ADDR_W, 5, register address width (RegNumLog2)

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- stall_mem  input  1  memory stage stalled (stall[4])
- stall_wb  input  1  write-back stage stalled (stall[5])
- flush  input  1  exception/eret pipeline flush
- mem_valid  input  1  memory stage holds a real instruction
- mem_we  input  1  instruction writes a GPR
- mem_waddr  input  5  destination GPR
- mem_wdata  input  32  ALU/non-load result
- mem_load_op  input  3  0=none, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW; 6-7 reserved, treated as none
- mem_addr_lo  input  2  effective address bits [1:0]
- mem_rdata  input  32  raw data-RAM word, valid in the same cycle as the other mem_* inputs
- mem_whilo, mem_hi, mem_lo  input  1/32/32  HI/LO write request (present only with MEM_WB_HILO_EN)
- wb_we  output  1  to regfile we
- wb_waddr  output  5  to regfile waddr
- wb_wdata  output  32  to regfile wdata (aligned load data or ALU result)
- wb_valid  output  1  WB holds a real instruction
- wb_whilo, wb_hi, wb_lo  output  1/32/32  to HI/LO register (present only with MEM_WB_HILO_EN)
- retire_cnt  output  32  instructions retired since reset

Behaviour:
- Reset is asynchronous, active-high, clocked by clk.
- Reset values: all outputs 0; internal registers (raw word, load_op, addr_lo) 0.
- Per rising edge, priority order:
  1. flush: load a bubble.
  2. stall_mem=1 and stall_wb=0: load a bubble.
  3. stall_mem=0: capture the mem_* inputs.
  4. Otherwise (stall_wb=1): hold all state.
- Bubble: wb_valid=0, wb_we=0, wb_waddr=0, stored data=0, wb_whilo=0, load_op=none.
- Capture:
  - wb_valid <= mem_valid.
  - wb_we <= mem_we & mem_valid & (mem_waddr != 0).
  - wb_waddr <= mem_waddr.
  - Registers mem_wdata, mem_rdata, mem_load_op and mem_addr_lo.
- wb_wdata is combinational from registered state, zero extra latency. Byte lanes are big-endian: lane 0 = bits 31:24.
  - none: stored ALU result.
  - LB/LBU: byte at addr_lo, sign-/zero-extended.
  - LH/LHU: addr_lo[1]=0 selects [31:16], addr_lo[1]=1 selects [15:0], sign-/zero-extended; addr_lo[0] ignored (alignment exceptions are raised upstream).
  - LW: full raw word; addr_lo ignored.
- Latency: one cycle from mem_* sampled to wb_* visible. The regfile's same-cycle write bypass resolves the RAW hazard with decode.
- retire_cnt:
  - Increments by 1 on each edge that captures with mem_valid=1.
  - No increment on bubble, hold, or flush.
  - Wraps 0xFFFFFFFF -> 0.
- Flush together with stall_wb: flush wins, outputs become a bubble.
- Reset mid-stall: outputs clear immediately, independent of clk.

Optional Feature:
- Macro: MEM_WB_HILO_EN.
- Defined: HI/LO ports exist; wb_whilo/wb_hi/wb_lo follow the same capture/bubble/hold rules as wb_we, and wb_whilo is gated by mem_valid.
- Undefined: HI/LO ports are absent and no HI/LO registers are built.

Decomposition:
- Shared defines package:
  - RstEnable, WriteEnable, ZeroWord, RegBus, RegAddrBus.
  - Load-op encodings LOAD_NONE..LOAD_LW.
  - Stall vector indices.
- Sub-module load_align (purely combinational): inputs raw word, load_op, addr_lo; output formatted 32-bit result. Instantiated once.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 asynchronously. Release, then capture mem_we=1, mem_waddr=4, mem_wdata=0x12345678 -> next cycle wb_we=1, wb_waddr=4, wb_wdata=0x12345678, retire_cnt=1.
- Loads with mem_rdata=0x80FF7F01:
  - LB addr_lo=0 -> 0xFFFFFF80; LBU addr_lo=1 -> 0x000000FF; LB addr_lo=2 -> 0x0000007F.
  - LH addr_lo=2 -> 0x00007F01; LHU addr_lo=0 -> 0x000080FF; LH addr_lo=0 -> 0xFFFF80FF.
  - LW -> 0x80FF7F01.
- Stalls:
  - stall_mem=1, stall_wb=0 for 2 cycles -> wb_valid=0, wb_we=0, retire_cnt unchanged.
  - stall_mem=1, stall_wb=1 -> previous wb_* held for the stall duration.
- Flush while stall_wb=1 and WB holds waddr=19 -> next edge wb_we=0, wb_valid=0.
- Zero register: capture mem_we=1, mem_waddr=0, mem_valid=1 -> wb_we=0, wb_valid=1, retire_cnt increments.
- Counter wrap: force retire_cnt to 0xFFFFFFFF, capture one valid instruction -> retire_cnt=0.
- With MEM_WB_HILO_EN, capture mem_whilo=1, mem_hi=0xA, mem_lo=0xB -> wb_whilo=1, wb_hi=0xA, wb_lo=0xB. Next bubble -> wb_whilo=0.

Source files
------------

// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared defines, load-op encodings and stall indices for the MEM/WB stage
package mem_wb_stage_pkg;

  // Datapath and register-address widths of the MIPS32 core
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  // Legacy-style control levels, kept so stage code reads like the rest of the core
  localparam logic RstEnable   = 1'b1;
  localparam logic WriteEnable = 1'b1;
  localparam logic [DATA_W-1:0] ZeroWord = '0;

  typedef logic [DATA_W-1:0] RegBus;
  typedef logic [ADDR_W-1:0] RegAddrBus;

  // Load-op encodings carried down the pipe; 6 and 7 are reserved and mean "no load"
  typedef enum logic [2:0] {
    LOAD_NONE = 3'd0,
    LOAD_LB   = 3'd1,
    LOAD_LBU  = 3'd2,
    LOAD_LH   = 3'd3,
    LOAD_LHU  = 3'd4,
    LOAD_LW   = 3'd5
  } load_op_e;

  // Positions of the MEM and WB stall bits inside the core-wide stall vector
  localparam int STALL_MEM_IDX = 4;
  localparam int STALL_WB_IDX  = 5;

  // True when the encoding names a real load (reserved codes fall back to ALU data)
  function automatic logic is_load(input logic [2:0] op);
    logic hit;
    hit = 1'b0;
    case (op)
      LOAD_LB, LOAD_LBU, LOAD_LH, LOAD_LHU, LOAD_LW: hit = 1'b1;
      default: hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - big-endian byte/halfword extraction and extension of load data
module mem_wb_stage_load_align
  import mem_wb_stage_pkg::*;
(
  input  logic [DATA_W-1:0] raw,
  input  logic [2:0]        load_op,
  input  logic [1:0]        addr_lo,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Select the addressed byte and halfword; lane 0 is the most significant byte
  always_comb begin
    byte_lane = raw[31:24];
    case (addr_lo)
      2'd0:    byte_lane = raw[31:24];
      2'd1:    byte_lane = raw[23:16];
      2'd2:    byte_lane = raw[15:8];
      default: byte_lane = raw[7:0];
    endcase
    // addr_lo[0] is ignored here: misaligned halfwords trap before reaching this stage
    half_lane = addr_lo[1] ? raw[15:0] : raw[31:16];
  end

  // Extend the selected lane according to the load type; non-loads pass the raw word through
  always_comb begin
    result = raw;
    case (load_op)
      LOAD_LB:  result = {{24{byte_lane[7]}}, byte_lane};
      LOAD_LBU: result = {24'h000000, byte_lane};
      LOAD_LH:  result = {{16{half_lane[15]}}, half_lane};
      LOAD_LHU: result = {16'h0000, half_lane};
      LOAD_LW:  result = raw;
      default:  result = raw;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB pipeline register and write-back formatter; optional HI/LO path via MEM_WB_HILO_EN
module mem_wb_stage
  import mem_wb_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_mem,
  input  logic              stall_wb,
  input  logic              flush,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [2:0]        mem_load_op,
  input  logic [1:0]        mem_addr_lo,
  input  logic [DATA_W-1:0] mem_rdata,
`ifdef MEM_WB_HILO_EN
  input  logic              mem_whilo,
  input  logic [DATA_W-1:0] mem_hi,
  input  logic [DATA_W-1:0] mem_lo,
`endif
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [DATA_W-1:0] wb_wdata,
  output logic              wb_valid,
`ifdef MEM_WB_HILO_EN
  output logic              wb_whilo,
  output logic [DATA_W-1:0] wb_hi,
  output logic [DATA_W-1:0] wb_lo,
`endif
  output logic [DATA_W-1:0] retire_cnt
);

  logic [STALL_WB_IDX:STALL_MEM_IDX] stall_pair;
  logic  bubble;
  logic  capture;
  RegBus alu_q;
  RegBus raw_q;
  RegBus aligned;
  logic [2:0] load_op_q;
  logic [1:0] addr_lo_q;

  // Keep the stall bits at their core-wide indices so this stage reads like the stall vector
  assign stall_pair = {stall_wb, stall_mem};

  // A flush, or MEM stalled while WB drains, inserts a bubble; MEM running means capture
  assign bubble  = flush | (stall_pair[STALL_MEM_IDX] & ~stall_pair[STALL_WB_IDX]);
  assign capture = ~bubble & ~stall_pair[STALL_MEM_IDX];

  // Pipeline register: reset, bubble, capture, or hold when both stages are stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      alu_q     <= ZeroWord;
      raw_q     <= ZeroWord;
      load_op_q <= LOAD_NONE;
      addr_lo_q <= 2'd0;
    end else if (bubble) begin
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      alu_q     <= ZeroWord;
      raw_q     <= ZeroWord;
      load_op_q <= LOAD_NONE;
      addr_lo_q <= 2'd0;
    end else if (capture) begin
      wb_valid  <= mem_valid;
      // $zero is hard-wired, so a write to it is dropped here rather than in the regfile
      wb_we     <= (mem_we == WriteEnable) & mem_valid & (mem_waddr != '0);
      wb_waddr  <= mem_waddr;
      alu_q     <= mem_wdata;
      raw_q     <= mem_rdata;
      load_op_q <= mem_load_op;
      addr_lo_q <= mem_addr_lo;
    end
  end

  // Count every real instruction that enters WB; wraps naturally at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      retire_cnt <= ZeroWord;
    end else if (capture && mem_valid) begin
      retire_cnt <= retire_cnt + 32'd1;
    end
  end

`ifdef MEM_WB_HILO_EN
  // HI/LO write-back follows the GPR port: same bubble/capture/hold, gated by mem_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      wb_whilo <= 1'b0;
      wb_hi    <= ZeroWord;
      wb_lo    <= ZeroWord;
    end else if (bubble) begin
      wb_whilo <= 1'b0;
      wb_hi    <= ZeroWord;
      wb_lo    <= ZeroWord;
    end else if (capture) begin
      wb_whilo <= mem_whilo & mem_valid;
      wb_hi    <= mem_hi;
      wb_lo    <= mem_lo;
    end
  end
`endif

  // Format load data from the registered raw word so WB adds no extra cycle
  mem_wb_stage_load_align u_load_align (
    .raw     (raw_q),
    .load_op (load_op_q),
    .addr_lo (addr_lo_q),
    .result  (aligned)
  );

  assign wb_wdata = is_load(load_op_q) ? aligned : alu_q;

endmodule
